// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, widths and issue-entry type
package alu_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int RBITS_DEF = 5;

    // Arithmetic / compare group
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    // Logic group, identified by op[3:2] == 2'b01
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    // Shift group
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;

    // One held op; widths follow the package defaults, so the stage
    // parameters are expected to stay at those defaults.
    typedef struct packed {
        logic                 valid;
        logic [XLEN_DEF-1:0]  a;
        logic [XLEN_DEF-1:0]  b;
        logic [RBITS_DEF-1:0] rs1;
        logic [RBITS_DEF-1:0] rs2;
        logic                 b_is_imm;
        logic [3:0]           aluop;
        logic [RBITS_DEF-1:0] rd;
    } issue_entry_t;

    function automatic logic is_logic_op(input logic [3:0] op);
        return op[3:2] == 2'b01;
    endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// rtl/alu_fwd_mux.sv - writeback bypass select for one operand
module alu_fwd_mux #(
    parameter int XLEN  = 32,
    parameter int RBITS = 5
) (
    input  logic [XLEN-1:0]  operand,
    input  logic [RBITS-1:0] src,
    input  logic             is_imm,
    input  logic             fwd_en,
    input  logic [RBITS-1:0] fwd_rd,
    input  logic [XLEN-1:0]  fwd_data,
    output logic [XLEN-1:0]  result
);

    logic hit;

    // Register 0 is hardwired, and immediates never name a register
    assign hit    = fwd_en && (fwd_rd != '0) && (fwd_rd == src) && !is_imm;
    assign result = hit ? fwd_data : operand;

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - registered ALU issue stage with skid buffer and forwarding
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RBITS = RBITS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [RBITS-1:0] in_rs1,
    input  logic [RBITS-1:0] in_rs2,
    input  logic             in_b_is_imm,
    input  logic [3:0]       in_aluop,
    input  logic [RBITS-1:0] in_rd,
    input  logic             fwd_en,
    input  logic [RBITS-1:0] fwd_rd,
    input  logic [XLEN-1:0]  fwd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_a,
    output logic [XLEN-1:0]  out_b,
    output logic [3:0]       out_aluop,
    output logic [RBITS-1:0] out_rd,
    output logic             out_is_logic
);

    issue_entry_t h_q, s_q, h_d, s_d;
    issue_entry_t in_ent, h_fwd, s_fwd;

    logic [XLEN-1:0] in_a_f, in_b_f, h_a_f, h_b_f, s_a_f, s_b_f;
    logic            accept, pop;

    alu_fwd_mux #(.XLEN(XLEN), .RBITS(RBITS)) u_fwd_in_a (
        .operand(in_a), .src(in_rs1), .is_imm(1'b0),
        .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .result(in_a_f)
    );
    alu_fwd_mux #(.XLEN(XLEN), .RBITS(RBITS)) u_fwd_in_b (
        .operand(in_b), .src(in_rs2), .is_imm(in_b_is_imm),
        .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .result(in_b_f)
    );
    alu_fwd_mux #(.XLEN(XLEN), .RBITS(RBITS)) u_fwd_h_a (
        .operand(h_q.a), .src(h_q.rs1), .is_imm(1'b0),
        .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .result(h_a_f)
    );
    alu_fwd_mux #(.XLEN(XLEN), .RBITS(RBITS)) u_fwd_h_b (
        .operand(h_q.b), .src(h_q.rs2), .is_imm(h_q.b_is_imm),
        .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .result(h_b_f)
    );
    alu_fwd_mux #(.XLEN(XLEN), .RBITS(RBITS)) u_fwd_s_a (
        .operand(s_q.a), .src(s_q.rs1), .is_imm(1'b0),
        .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .result(s_a_f)
    );
    alu_fwd_mux #(.XLEN(XLEN), .RBITS(RBITS)) u_fwd_s_b (
        .operand(s_q.b), .src(s_q.rs2), .is_imm(s_q.b_is_imm),
        .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .result(s_b_f)
    );

    // S only fills while H is occupied, so "S empty" is exactly "room left";
    // deriving it from a register keeps out_ready off the upstream path.
    assign in_ready = !s_q.valid;
    assign accept   = in_valid && in_ready;
    assign pop      = h_q.valid && out_ready;

    // Assemble the incoming op and the held entries with bypass applied
    always_comb begin
        in_ent          = '0;
        in_ent.valid    = 1'b1;
        in_ent.a        = in_a_f;
        in_ent.b        = in_b_f;
        in_ent.rs1      = in_rs1;
        in_ent.rs2      = in_rs2;
        in_ent.b_is_imm = in_b_is_imm;
        in_ent.aluop    = in_aluop;
        in_ent.rd       = in_rd;
        h_fwd           = h_q;
        h_fwd.a         = h_a_f;
        h_fwd.b         = h_b_f;
        s_fwd           = s_q;
        s_fwd.a         = s_a_f;
        s_fwd.b         = s_b_f;
    end

    // FIFO next-state for head and skid; flush overrides every move
    always_comb begin
        h_d = h_fwd;
        s_d = s_fwd;
        if (pop) begin
            if (s_q.valid) begin
                h_d       = s_fwd;
                s_d.valid = 1'b0;
            end else if (accept) begin
                h_d = in_ent;
            end else begin
                h_d.valid = 1'b0;
            end
        end else if (accept) begin
            if (!h_q.valid) begin
                h_d = in_ent;
            end else begin
                s_d = in_ent;
            end
        end
        if (flush) begin
            h_d.valid = 1'b0;
            s_d.valid = 1'b0;
        end
    end

    // Entry registers; reset zeroes everything so outputs read 0
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q <= '0;
            s_q <= '0;
        end else begin
            h_q <= h_d;
            s_q <= s_d;
        end
    end

    assign out_valid    = h_q.valid;
    assign out_a        = h_q.a;
    assign out_b        = h_q.b;
    assign out_aluop    = h_q.aluop;
    assign out_rd       = h_q.rd;
    assign out_is_logic = is_logic_op(h_q.aluop);

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Registered issue stage between decode and the ALU (logic/arith/shift units); ALU consumes its outputs directly.
- Captures operands, 4-bit ALU op and destination register under a valid/ready handshake.
- Absorbs downstream stalls with a 2-entry skid buffer.
- Applies writeback forwarding at capture time and to held entries. Supports a synchronous flush.

Parameters:
- XLEN, 32, operand width
- RBITS, 5, register index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  discard all held entries
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage can accept
- in_a  in  XLEN  operand A value from register file
- in_b  in  XLEN  operand B value (register or immediate)
- in_rs1  in  RBITS  source index for A
- in_rs2  in  RBITS  source index for B
- in_b_is_imm  in  1  B is immediate; never forwarded
- in_aluop  in  4  ALU operation code
- in_rd  in  RBITS  destination index
- fwd_en  in  1  writeback result valid this cycle
- fwd_rd  in  RBITS  writeback destination
- fwd_data  in  XLEN  writeback value
- out_valid  out  1  head entry valid
- out_ready  in  1  ALU accepts head
- out_a  out  XLEN  head operand A
- out_b  out  XLEN  head operand B
- out_aluop  out  4  head op
- out_rd  out  RBITS  head destination
- out_is_logic  out  1  out_aluop[3:2]==2'b01 (AND/OR/XOR/NOR group)

Behaviour:
- Clock, reset and flush:
  - Single clock clk; reset synchronous, active-high.
  - On reset: both entries invalid; out_valid=0, in_ready=1; out_a, out_b, out_aluop, out_rd, out_is_logic all 0.
- Storage: 2 entries, head (H) and skid (S). Each holds valid, a, b, rs1, rs2, b_is_imm, aluop, rd. Outputs are driven directly from H registers (no comb path from in_* to out_*).
- Handshakes:
  - Accept when in_valid & in_ready. Pop when out_valid & out_ready.
  - in_ready = !S.valid, registered, so upstream sees no comb dependence on out_ready.
  - Transfer latency: 1 cycle, in → H.
- Next-state rules:
  - pop & accept with S empty: H ← input.
  - pop with S valid: H ← S; an accept cannot occur in that cycle because in_ready=0.
  - accept with no pop: H empty → H ← input; H full → S ← input.
  - Ordering is strictly FIFO.
- Forwarding, evaluated every cycle:
  - Applies when fwd_en & fwd_rd!=0 & fwd_rd==rs1; likewise for rs2 when !b_is_imm.
  - Applies to the incoming op as it is captured, and to both H and S while they are held.
  - The forwarded value replaces the stored operand and is visible on out_* the following cycle.
  - Register 0 is never forwarded.
- Flush:
  - Next cycle H.valid=S.valid=0 and in_ready=1.
  - An input accepted in the same cycle as flush is discarded; flush wins.
  - Data registers may retain stale values; verification checks valid only.
- Simultaneous pop and forwarding to S: the forwarded value travels into H.
- Reset asserted mid-stall clears both entries; an op in flight is lost.
- out_aluop is passed unchanged; codes outside the defined set propagate. out_is_logic is decoded from the registered op.

Decomposition:
- Package alu_pkg holds:
  - ALU op constants: ALU_AND=4'b0100, ALU_OR=4'b0101, ALU_XOR=4'b0110, ALU_NOR=4'b0111, plus the arithmetic/shift codes.
  - XLEN and RBITS defaults.
  - The issue-entry struct typedef.
- Natural sub-module: alu_fwd_mux. Takes a stored operand, its source index, an imm flag and the fwd_* signals, and returns the selected operand. It is instantiated 6 times: A and B for each of input, H and S.

Test Plan:
- Basic flow: in_a=0xF0F0_F0F0, in_b=0x0FF0_0FF0, aluop=4'b0100, rd=3, out_ready=1 → next cycle out_valid=1, out_a/out_b match, out_is_logic=1; throughput 1 op/cycle over 10 back-to-back ops.
- Stall/skid: out_ready=0, send ops 1, 2 → in_ready falls after op 2; op 3 is held upstream. Release out_ready → ops emerge in order 1, 2, 3 with none lost or duplicated.
- Forwarding at capture: in_rs1=5, in_a=0x1, fwd_en=1, fwd_rd=5, fwd_data=0xDEAD_BEEF → out_a=0xDEAD_BEEF. Same case with fwd_rd=0 and in_rs1=0 → out_a=0x1.
- Forwarding while stalled:
  - Op held in S with rs2=7, b_is_imm=0; fwd_rd=7, fwd_data=0x55 → that op emerges with out_b=0x55.
  - Same with b_is_imm=1 → out_b is unchanged.
- Flush: both entries full, flush=1 together with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed-cycle op never appears.
- Reset: assert reset mid-stall with 2 entries held → next cycle out_valid=0, in_ready=1, all out_* = 0.
